// File: rtl/rv32i_fwd_pkg.sv
// rv32i_fwd_pkg: shared types for decode-stage operand resolution.
// The resolve struct carries a fixed-width value, so XLEN is limited to XLEN_MAX.
package rv32i_fwd_pkg;
    localparam int XLEN_MAX  = 64;
    localparam int SRC_IDX_W = 4;
    typedef logic [4:0] reg_idx_t;
    localparam reg_idx_t REG_X0 = 5'd0;
    typedef struct packed {
        logic [XLEN_MAX-1:0]  value;
        logic                 hazard;
        logic                 from_fwd;
        logic [SRC_IDX_W-1:0] src_idx;
    } resolve_t;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: resolves one source operand against the producer stages.
// The youngest match (lowest k) wins; in interlock mode any match hazards the slot.
module fwd_select
    import rv32i_fwd_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 3,
    parameter bit FWD_EN  = 1'b1
) (
    input  reg_idx_t                 rs_i,
    input  logic [XLEN-1:0]          rf_rdata_i,
    input  logic [NUM_FWD-1:0]       fwd_valid_i,
    input  logic [NUM_FWD-1:0]       fwd_wb_i,
    input  logic [NUM_FWD*5-1:0]     fwd_rd_i,
    input  logic [NUM_FWD*XLEN-1:0]  fwd_data_i,
    input  logic [NUM_FWD-1:0]       fwd_data_rdy_i,
    output resolve_t                 res_o
);
    logic [NUM_FWD-1:0] match;

    for (genvar k = 0; k < NUM_FWD; k++) begin : g_match
        assign match[k] = fwd_valid_i[k] && fwd_wb_i[k] && fwd_rd_i[5*k +: 5] == rs_i && rs_i != REG_X0;
    end

    // Walk oldest to youngest so the youngest match overrides.
    always_comb begin
        res_o = '0;
        res_o.value[XLEN-1:0] = (rs_i == REG_X0) ? '0 : rf_rdata_i;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (match[k]) begin
                res_o.from_fwd        = 1'b1;
                res_o.src_idx         = SRC_IDX_W'(k);
                res_o.value[XLEN-1:0] = FWD_EN ? fwd_data_i[XLEN*k +: XLEN] : rf_rdata_i;
                res_o.hazard          = !FWD_EN || !fwd_data_rdy_i[k];
            end
        end
    end
endmodule

// File: rtl/id_operand_fwd.sv
// id_operand_fwd: decode-to-EX operand read, RAW forwarding/interlock,
// valid/ready operand register and saturating stall counter.
module id_operand_fwd
    import rv32i_fwd_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_SRC     = 2,
    parameter int NUM_FWD     = 3,
    parameter int PAYLOAD_W   = 64,
    parameter bit FWD_EN      = 1'b1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_SRC*5-1:0]     in_rs,
    input  logic [4:0]               in_rd,
    input  logic                     in_wb,
    input  logic [PAYLOAD_W-1:0]     in_payload,
    output logic [NUM_SRC*5-1:0]     rf_raddr,
    input  logic [NUM_SRC*XLEN-1:0]  rf_rdata,
    input  logic [NUM_FWD-1:0]       fwd_valid,
    input  logic [NUM_FWD-1:0]       fwd_wb,
    input  logic [NUM_FWD*5-1:0]     fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0]  fwd_data,
    input  logic [NUM_FWD-1:0]       fwd_data_rdy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_SRC*XLEN-1:0]  out_operands,
    output logic [4:0]               out_rd,
    output logic                     out_wb,
    output logic [PAYLOAD_W-1:0]     out_payload,
    output logic [STALL_CNT_W-1:0]   stall_cnt
);
    resolve_t                 res [NUM_SRC];
    logic [NUM_SRC-1:0]       slot_haz;
    logic [NUM_SRC-1:0]       unused_res;
    logic [NUM_SRC*XLEN-1:0]  operands;
    logic                     hazard, accept;
    logic                     out_valid_d, out_valid_q;
    logic [STALL_CNT_W-1:0]   stall_cnt_d, stall_cnt_q;
    logic [NUM_SRC*XLEN-1:0]  operands_q;
    reg_idx_t                 rd_q;
    logic                     wb_q;
    logic [PAYLOAD_W-1:0]     payload_q;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_slot
        fwd_select #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .FWD_EN(FWD_EN)) u_sel (
            .rs_i           (in_rs[5*s +: 5]),
            .rf_rdata_i     (rf_rdata[XLEN*s +: XLEN]),
            .fwd_valid_i    (fwd_valid),
            .fwd_wb_i       (fwd_wb),
            .fwd_rd_i       (fwd_rd),
            .fwd_data_i     (fwd_data),
            .fwd_data_rdy_i (fwd_data_rdy),
            .res_o          (res[s])
        );
        assign slot_haz[s]               = res[s].hazard;
        assign operands[XLEN*s +: XLEN]  = res[s].value[XLEN-1:0];
        assign unused_res[s]             = ^res[s];
    end

    assign rf_raddr    = in_rs;
    assign hazard      = in_valid && |slot_haz;
    assign in_ready    = !hazard && (!out_valid_q || out_ready) && !flush;
    assign accept      = in_valid && in_ready;
    assign out_valid_d = flush ? 1'b0 : accept ? 1'b1 : out_valid_q && !out_ready;
    assign stall_cnt_d = (hazard && !flush && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            stall_cnt_q <= '0;
            operands_q  <= '0;
            rd_q        <= REG_X0;
            wb_q        <= 1'b0;
            payload_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            stall_cnt_q <= stall_cnt_d;
            if (accept) begin
                operands_q <= operands;
                rd_q       <= in_rd;
                wb_q       <= in_wb;
                payload_q  <= in_payload;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_operands = operands_q;
    assign out_rd       = rd_q;
    assign out_wb       = wb_q;
    assign out_payload  = payload_q;
    assign stall_cnt    = stall_cnt_q;
endmodule
